// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 configuration sequencer: ROM entry layout,
// marker codes, FSM state encoding and the SCCB device address.
package ov5640_pkg;

  localparam int REG_HI = 23;
  localparam int REG_LO = 8;
  localparam int DAT_HI = 7;
  localparam int DAT_LO = 0;

  localparam logic [15:0] CFG_END       = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY     = 16'hFFFE;
  localparam logic [7:0]  SCCB_DEV_ADDR = 8'h78;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PWR_DN    = 4'd1,
    S_RST_LO    = 4'd2,
    S_BOOT      = 4'd3,
    S_FETCH     = 4'd4,
    S_DECODE    = 4'd5,
    S_WAIT_ACK  = 4'd6,
    S_RETRY_GAP = 4'd7,
    S_DELAY     = 4'd8,
    S_NEXT      = 4'd9,
    S_DONE      = 4'd10,
    S_ERROR     = 4'd11
  } cfg_state_e;

  function automatic logic [31:0] ms_to_cycles(input logic [31:0] ms, input logic [31:0] ms_cycles);
    return ms * ms_cycles;
  endfunction

endpackage

// File: rtl/cfg_ms_timer.sv
// 32-bit load/down-count timer; expire marks the cycle whose edge brings the count to zero.
module cfg_ms_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        expire
);

  logic [31:0] cnt_r;

  // Down-counter: reload on request, otherwise count toward zero and hold there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 32'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != 32'd0) begin
      cnt_r <= cnt_r - 32'd1;
    end
  end

  // Flagging at 1 lets a waiting state leave exactly on the edge the count hits 0.
  assign expire = (cnt_r == 32'd1);

endmodule

// File: rtl/ov5640_cfg_sequencer.sv
// OV5640 power-up sequencer and configuration-ROM walker issuing SCCB register writes,
// with embedded delay entries, per-write NACK retry and done/error reporting.
module ov5640_cfg_sequencer
  import ov5640_pkg::*;
#(
  parameter int unsigned ROM_AW    = 8,
  parameter int unsigned MS_CYCLES = 100000,
  parameter int unsigned T_PWDN_MS = 1,
  parameter int unsigned T_RST_MS  = 1,
  parameter int unsigned T_BOOT_MS = 20,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic              sccb_req,
  output logic [15:0]       sccb_reg_addr,
  output logic [7:0]        sccb_data,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  output logic              cam_pwdn,
  output logic              cam_resetb,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic [ROM_AW-1:0] err_index
);

  cfg_state_e        state_r, state_nxt_s;
  logic [7:0]        retry_r, retry_nxt_s;
  logic [ROM_AW-1:0] rom_addr_nxt_s, err_index_nxt_s;
  logic [15:0]       reg_addr_nxt_s, entry_reg_s;
  logic [7:0]        data_nxt_s, entry_dat_s;
  logic              req_nxt_s, pwdn_nxt_s, resetb_nxt_s;
  logic              busy_nxt_s, done_nxt_s, error_nxt_s;
  logic              tmr_load_s, tmr_expire_s;
  logic [31:0]       tmr_val_s;

  assign entry_reg_s = rom_data[REG_HI:REG_LO];
  assign entry_dat_s = rom_data[DAT_HI:DAT_LO];

  cfg_ms_timer u_timer (
    .clk      (sys_clock),
    .rst_n    (reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .expire   (tmr_expire_s)
  );

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    state_nxt_s     = state_r;
    rom_addr_nxt_s  = rom_addr;
    req_nxt_s       = sccb_req;
    reg_addr_nxt_s  = sccb_reg_addr;
    data_nxt_s      = sccb_data;
    pwdn_nxt_s      = cam_pwdn;
    resetb_nxt_s    = cam_resetb;
    busy_nxt_s      = busy;
    done_nxt_s      = cfg_done;
    error_nxt_s     = cfg_error;
    err_index_nxt_s = err_index;
    retry_nxt_s     = retry_r;
    tmr_load_s      = 1'b0;
    tmr_val_s       = 32'd0;
    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        // Any restart is a full re-init, including the camera power cycle.
        if (start) begin
          state_nxt_s     = S_PWR_DN;
          busy_nxt_s      = 1'b1;
          pwdn_nxt_s      = 1'b1;
          resetb_nxt_s    = 1'b0;
          rom_addr_nxt_s  = '0;
          retry_nxt_s     = 8'd0;
          done_nxt_s      = 1'b0;
          error_nxt_s     = 1'b0;
          err_index_nxt_s = '0;
          tmr_load_s      = 1'b1;
          tmr_val_s       = ms_to_cycles(T_PWDN_MS, MS_CYCLES);
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_PWR_DN: begin
        if (tmr_expire_s) begin
          state_nxt_s = S_RST_LO;
          pwdn_nxt_s  = 1'b0;
          tmr_load_s  = 1'b1;
          tmr_val_s   = ms_to_cycles(T_RST_MS, MS_CYCLES);
        end else begin
          state_nxt_s = S_PWR_DN;
        end
      end
      S_RST_LO: begin
        if (tmr_expire_s) begin
          state_nxt_s  = S_BOOT;
          resetb_nxt_s = 1'b1;
          tmr_load_s   = 1'b1;
          tmr_val_s    = ms_to_cycles(T_BOOT_MS, MS_CYCLES);
        end else begin
          state_nxt_s = S_RST_LO;
        end
      end
      S_BOOT: begin
        if (tmr_expire_s) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_BOOT;
        end
      end
      S_FETCH: state_nxt_s = S_DECODE;
      S_DECODE: begin
        if (entry_reg_s == CFG_END) begin
          state_nxt_s = S_DONE;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
        end else if (entry_reg_s == CFG_DELAY) begin
          if (entry_dat_s == 8'd0) begin
            state_nxt_s = S_NEXT;
          end else begin
            state_nxt_s = S_DELAY;
            tmr_load_s  = 1'b1;
            tmr_val_s   = ms_to_cycles({24'd0, entry_dat_s}, MS_CYCLES);
          end
        end else begin
          state_nxt_s    = S_WAIT_ACK;
          reg_addr_nxt_s = entry_reg_s;
          data_nxt_s     = entry_dat_s;
          req_nxt_s      = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (sccb_done) begin
          req_nxt_s = 1'b0;
          if (!sccb_nack) begin
            state_nxt_s = S_NEXT;
          end else if (retry_r < 8'(MAX_RETRY)) begin
            state_nxt_s = S_RETRY_GAP;
            retry_nxt_s = retry_r + 8'd1;
          end else begin
            state_nxt_s     = S_ERROR;
            err_index_nxt_s = rom_addr;
            busy_nxt_s      = 1'b0;
            error_nxt_s     = 1'b1;
          end
        end else begin
          state_nxt_s = S_WAIT_ACK;
        end
      end
      S_RETRY_GAP: begin
        state_nxt_s = S_WAIT_ACK;
        req_nxt_s   = 1'b1;
      end
      S_DELAY: begin
        if (tmr_expire_s) begin
          state_nxt_s = S_NEXT;
        end else begin
          state_nxt_s = S_DELAY;
        end
      end
      S_NEXT: begin
        retry_nxt_s = 8'd0;
        // The last ROM slot acts as an implicit end marker; the address never wraps.
        if (rom_addr == {ROM_AW{1'b1}}) begin
          state_nxt_s = S_DONE;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s    = S_FETCH;
          rom_addr_nxt_s = rom_addr + ROM_AW'(1);
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      retry_r       <= 8'd0;
      rom_addr      <= '0;
      sccb_req      <= 1'b0;
      sccb_reg_addr <= 16'd0;
      sccb_data     <= 8'd0;
      cam_pwdn      <= 1'b1;
      cam_resetb    <= 1'b0;
      busy          <= 1'b0;
      cfg_done      <= 1'b0;
      cfg_error     <= 1'b0;
      err_index     <= '0;
    end else begin
      state_r       <= state_nxt_s;
      retry_r       <= retry_nxt_s;
      rom_addr      <= rom_addr_nxt_s;
      sccb_req      <= req_nxt_s;
      sccb_reg_addr <= reg_addr_nxt_s;
      sccb_data     <= data_nxt_s;
      cam_pwdn      <= pwdn_nxt_s;
      cam_resetb    <= resetb_nxt_s;
      busy          <= busy_nxt_s;
      cfg_done      <= done_nxt_s;
      cfg_error     <= error_nxt_s;
      err_index     <= err_index_nxt_s;
    end
  end

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// Bench for ov5640_cfg_sequencer: table of ROM scenarios with a write scoreboard,
// plus hand sequences for start-while-busy and reset during a transfer.
module tb_ov5640_cfg_sequencer;
  localparam int MAX_RETRY = 3;
  localparam int ACK_DLY   = 5;

  logic        sys_clock, reset, start;
  logic [1:0]  rom_addr, err_index;
  logic [23:0] rom_data;
  logic        sccb_req, sccb_done, sccb_nack;
  logic [15:0] sccb_reg_addr;
  logic [7:0]  sccb_data;
  logic        cam_pwdn, cam_resetb, busy, cfg_done, cfg_error;

  ov5640_cfg_sequencer #(
    .ROM_AW(2), .MS_CYCLES(10), .T_PWDN_MS(1), .T_RST_MS(1), .T_BOOT_MS(2), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .sys_clock(sys_clock), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_req(sccb_req), .sccb_reg_addr(sccb_reg_addr), .sccb_data(sccb_data),
    .sccb_done(sccb_done), .sccb_nack(sccb_nack),
    .cam_pwdn(cam_pwdn), .cam_resetb(cam_resetb), .busy(busy),
    .cfg_done(cfg_done), .cfg_error(cfg_error), .err_index(err_index)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        retry;
  } wr_t;

  typedef struct {
    logic [3:0][23:0] rom;
    logic [15:0]      nack_addr;
    int               nack_cnt;
    logic             exp_error;
    logic [1:0]       exp_last;
    logic [1:0]       exp_err_idx;
    int               exp_gap;
  } vec_t;

  wr_t              exp_q[$];
  vec_t             vecs[6];
  logic [3:0][23:0] rom_mem;
  logic [15:0]      nack_addr;
  int nack_left, ack_cnt, done_cnt, rise_cnt, extra_reqs;
  int cyc, start_edge, first_done_edge, first_rise_edge, second_rise_edge;
  int fall_edge, pwdn_fall_edge, resetb_rise_edge;
  int n_checks, n_fail;
  logic req_q, pwdn_q, resetb_q;

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;
  always @(posedge sys_clock) cyc <= cyc + 1;

  // Synchronous configuration ROM: data follows the address by one cycle.
  always @(posedge sys_clock) rom_data <= rom_mem[rom_addr];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic string nm(input int n, input string s);
    return $sformatf("v%0d_%s", n, s);
  endfunction

  function automatic vec_t mk_vec(input logic [3:0][23:0] rom, input logic [15:0] na, input int nc,
                                  input logic er, input logic [1:0] last, input logic [1:0] ei, input int gap);
    vec_t v;
    v.rom = rom; v.nack_addr = na; v.nack_cnt = nc; v.exp_error = er;
    v.exp_last = last; v.exp_err_idx = ei; v.exp_gap = gap;
    return v;
  endfunction

  // SCCB master model: acks ACK_DLY cycles after req, nacking nack_addr while nacks remain.
  always @(negedge sys_clock) begin
    sccb_done = 1'b0;
    sccb_nack = 1'b0;
    if (sccb_req) begin
      ack_cnt = ack_cnt + 1;
      if (ack_cnt >= ACK_DLY) begin
        ack_cnt   = 0;
        sccb_done = 1'b1;
        if (done_cnt == 0) first_done_edge = cyc + 1;
        done_cnt = done_cnt + 1;
        if (sccb_reg_addr == nack_addr && nack_left > 0) begin
          sccb_nack = 1'b1;
          nack_left = nack_left - 1;
        end
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // Monitor: scoreboard each req rise and timestamp pin transitions.
  always @(negedge sys_clock) begin
    wr_t e;
    if (sccb_req && !req_q) begin
      rise_cnt = rise_cnt + 1;
      if (rise_cnt == 1) first_rise_edge = cyc;
      if (rise_cnt == 2) second_rise_edge = cyc;
      if (exp_q.size() == 0) begin
        extra_reqs = extra_reqs + 1;
      end else begin
        e = exp_q.pop_front();
        check("req_addr", {16'd0, sccb_reg_addr}, {16'd0, e.addr});
        check("req_data", {24'd0, sccb_data}, {24'd0, e.data});
        if (e.retry) check("retry_low_gap", cyc - fall_edge, 1);
      end
    end
    if (!sccb_req && req_q) fall_edge = cyc;
    if (!cam_pwdn && pwdn_q) pwdn_fall_edge = cyc;
    if (cam_resetb && !resetb_q) resetb_rise_edge = cyc;
    req_q    = sccb_req;
    pwdn_q   = cam_pwdn;
    resetb_q = cam_resetb;
  end

  // Reference model: expected write sequence for a ROM image and NACK plan.
  task automatic push_expected(input vec_t v);
    logic [15:0] ra;
    int copies;
    for (int i = 0; i < 4; i++) begin
      ra = v.rom[i][23:8];
      if (ra == 16'hFFFF) break;
      if (ra == 16'hFFFE) continue;
      copies = 1;
      if (ra == v.nack_addr) copies = ((v.nack_cnt > MAX_RETRY) ? MAX_RETRY : v.nack_cnt) + 1;
      for (int k = 0; k < copies; k++) exp_q.push_back(wr_t'{ra, v.rom[i][7:0], k > 0});
      if (ra == v.nack_addr && v.nack_cnt > MAX_RETRY) break;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge sys_clock);
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pwdn"}, cam_pwdn, 1);
    check({tag, "_resetb"}, cam_resetb, 0);
    check({tag, "_req"}, sccb_req, 0);
    check({tag, "_reg_addr"}, sccb_reg_addr, 0);
    check({tag, "_data"}, sccb_data, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cfg_done"}, cfg_done, 0);
    check({tag, "_cfg_error"}, cfg_error, 0);
    check({tag, "_err_index"}, err_index, 0);
  endtask

  task automatic run_vec(input vec_t v, input int n, input bit poke);
    rise_cnt = 0; done_cnt = 0; extra_reqs = 0;
    exp_q.delete();
    rom_mem = v.rom; nack_addr = v.nack_addr; nack_left = v.nack_cnt;
    push_expected(v);
    @(negedge sys_clock);
    pulse_start();
    start_edge = cyc;
    check(nm(n, "busy_after_start"), busy, 1);
    if (poke) begin
      repeat (14) @(negedge sys_clock);
      pulse_start();
      for (int i = 0; i < 100 && !sccb_req; i++) @(negedge sys_clock);
      pulse_start();
    end
    for (int i = 0; i < 1000 && !(cfg_done || cfg_error); i++) @(negedge sys_clock);
    check(nm(n, "finished"), cfg_done | cfg_error, 1);
    repeat (20) @(negedge sys_clock);
    check(nm(n, "pwdn_fall"), pwdn_fall_edge - start_edge, 10);
    check(nm(n, "resetb_rise"), resetb_rise_edge - start_edge, 20);
    check(nm(n, "first_req"), first_rise_edge - start_edge, 42);
    check(nm(n, "done_to_req_gap"), second_rise_edge - first_done_edge, v.exp_gap);
    check(nm(n, "cfg_done"), cfg_done, !v.exp_error);
    check(nm(n, "cfg_error"), cfg_error, v.exp_error);
    check(nm(n, "err_index"), err_index, v.exp_err_idx);
    check(nm(n, "busy_end"), busy, 0);
    check(nm(n, "req_end"), sccb_req, 0);
    check(nm(n, "rom_addr_end"), rom_addr, v.exp_last);
    check(nm(n, "pins_end"), {cam_pwdn, cam_resetb}, 2'b01);
    check(nm(n, "extra_reqs"), extra_reqs, 0);
    check(nm(n, "missing_writes"), exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0; ack_cnt = 0; done_cnt = 0; rise_cnt = 0;
    extra_reqs = 0; nack_left = 0; nack_addr = 16'h0000; rom_mem = '0;
    req_q = 1'b0; pwdn_q = 1'b1; resetb_q = 1'b0;
    fall_edge = 0; pwdn_fall_edge = 0; resetb_rise_edge = 0;
    first_done_edge = 0; first_rise_edge = 0; second_rise_edge = 0;
    reset = 1'b0; start = 1'b0;

    // ROM images are listed highest index first: {[3], [2], [1], [0]}.
    vecs[0] = mk_vec({24'h000000, 24'hFFFF00, 24'h310303, 24'h300882}, 16'h0000, 0, 1'b0, 2'd2, 2'd0, 3);
    vecs[1] = mk_vec({24'hFFFF00, 24'h310303, 24'hFFFE03, 24'h300882}, 16'h0000, 0, 1'b0, 2'd3, 2'd0, 36);
    vecs[2] = mk_vec({24'hFFFF00, 24'h310303, 24'hFFFE00, 24'h300882}, 16'h0000, 0, 1'b0, 2'd3, 2'd0, 6);
    vecs[3] = mk_vec({24'h000000, 24'hFFFF00, 24'h310303, 24'h300882}, 16'h3103, 3, 1'b0, 2'd2, 2'd0, 3);
    vecs[4] = mk_vec({24'h000000, 24'hFFFF00, 24'h310303, 24'h300882}, 16'h3103, 4, 1'b1, 2'd1, 2'd1, 3);
    vecs[5] = mk_vec({24'h382106, 24'h382040, 24'h310303, 24'h300882}, 16'h0000, 0, 1'b0, 2'd3, 2'd0, 3);

    repeat (3) @(negedge sys_clock);
    check_reset_values("por");
    reset = 1'b1;
    repeat (2) @(negedge sys_clock);

    for (int n = 0; n < 6; n++) run_vec(vecs[n], n, 1'b0);

    // Start pulses while busy (power-up and mid-write) must not disturb the run.
    run_vec(vecs[0], 6, 1'b1);

    // Reset while a write is outstanding.
    rise_cnt = 0; done_cnt = 0; extra_reqs = 0;
    exp_q.delete();
    rom_mem = vecs[0].rom; nack_addr = 16'h0000; nack_left = 0;
    push_expected(vecs[0]);
    @(negedge sys_clock);
    pulse_start();
    for (int i = 0; i < 200 && !sccb_req; i++) @(negedge sys_clock);
    check("reset_seq_req_seen", sccb_req, 1);
    @(negedge sys_clock);
    #2 reset = 1'b0;
    #1 check_reset_values("async_rst");
    exp_q.delete();
    repeat (2) @(negedge sys_clock);
    reset = 1'b1;
    repeat (5) @(negedge sys_clock);
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_req", sccb_req, 0);
    run_vec(vecs[0], 7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ov5640_cfg_sequencer.md
Name: ov5640_cfg_sequencer

Overview:
- Power-up and register-init controller for the OV5640 camera.
- Drives camera PWDN/RESETB with timed waits, then walks a configuration ROM of {16-bit reg addr, 8-bit data} entries.
- Issues each entry as one SCCB register write through a write-level SCCB master port. Supports embedded delay entries and per-write NACK retry.
- Reports done/error status to the capture path and to software.

Parameters:
- ROM_AW, 8, ROM address width; the ROM holds up to 2^ROM_AW entries.
- MS_CYCLES, 100000, sys_clock cycles per millisecond.
- T_PWDN_MS, 1, time PWDN is held high after start.
- T_RST_MS, 1, time RESETB is held low after PWDN falls.
- T_BOOT_MS, 20, wait after RESETB rises before the first SCCB write.
- MAX_RETRY, 3, retries per entry after a NACK before declaring an error.

Ports:
- sys_clock  in  1  single clock for all logic
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE, DONE or ERROR
- rom_addr  out  ROM_AW  configuration ROM read address
- rom_data  in  24  {reg_addr[15:0], data[7:0]}; valid exactly 1 cycle after rom_addr changes
- sccb_req  out  1  write request; level signal, held until sccb_done
- sccb_reg_addr  out  16  register address; stable while sccb_req is high
- sccb_data  out  8  register data; stable while sccb_req is high
- sccb_done  in  1  one-cycle pulse from the master when a write completes
- sccb_nack  in  1  qualified by sccb_done; high means the slave did not acknowledge
- cam_pwdn  out  1  camera power-down, active high
- cam_resetb  out  1  camera reset, active low
- busy  out  1  high from start acceptance until DONE or ERROR
- cfg_done  out  1  level; high in DONE
- cfg_error  out  1  level; high in ERROR
- err_index  out  ROM_AW  ROM index of the failing entry; valid while cfg_error is high

Behaviour:
- Reset values: cam_pwdn=1, cam_resetb=0, sccb_req=0, sccb_reg_addr=0, sccb_data=0, rom_addr=0, busy=0, cfg_done=0, cfg_error=0, err_index=0. State=IDLE.
- Reset asserted mid-operation aborts immediately to reset values. This includes dropping sccb_req even during a master transfer.
- Timer: one 32-bit down-counter.
  - Load value = ms*MS_CYCLES.
  - A state waiting N ms exits on the cycle the counter reaches 0, i.e. N*MS_CYCLES cycles after entry.
- States and transitions:
  - IDLE: on start -> PWR_DN. busy=1, cam_pwdn=1, cam_resetb=0, rom_addr=0, retry count=0.
  - PWR_DN: wait T_PWDN_MS, then cam_pwdn=0 -> RST_LO.
  - RST_LO: wait T_RST_MS, then cam_resetb=1 -> BOOT.
  - BOOT: wait T_BOOT_MS -> FETCH.
  - FETCH: one cycle for ROM latency -> DECODE.
  - DECODE: registers rom_data and branches:
    - reg_addr==16'hFFFF: end marker -> DONE.
    - reg_addr==16'hFFFE: delay entry; load timer with data ms -> DELAY. data=0 means no wait; go straight to NEXT.
    - otherwise: load sccb_reg_addr/sccb_data, assert sccb_req -> WAIT_ACK.
  - WAIT_ACK:
    - On sccb_done: sccb_req goes low on the next edge.
    - If sccb_nack=0 -> NEXT.
    - If sccb_nack=1 and retry<MAX_RETRY: retry++, -> RETRY_GAP. RETRY_GAP holds req low for 1 cycle, then reasserts sccb_req with the same addr/data and returns to WAIT_ACK.
    - Otherwise err_index=rom_addr -> ERROR.
  - DELAY: wait until timer reaches 0 -> NEXT.
  - NEXT:
    - Reset retry to 0.
    - If rom_addr==2^ROM_AW-1 -> DONE. There is no wrap; the last ROM entry counts as an implicit end marker.
    - Else rom_addr++ -> FETCH.
  - DONE: busy=0, cfg_done=1. Camera pins stay powered (pwdn=0, resetb=1). On start -> PWR_DN, clearing cfg_done; this is a full re-init including the camera power cycle.
  - ERROR: busy=0, cfg_error=1, sccb_req=0. Camera pins are unchanged. On start -> PWR_DN, clearing cfg_error and err_index.
- start is ignored in every other state.
- sccb_done while sccb_req=0 is ignored.
- Throughput: at most one write in flight. The sequencer adds a minimum gap of 3 cycles between sccb_done and the next sccb_req rise (NEXT, FETCH, DECODE).
- ROM read latency is fixed at 1 cycle; rom_addr only changes in IDLE/start and NEXT.

Decomposition:
- Shared package ov5640_pkg holds:
  - entry field slices (REG_HI=23, REG_LO=8, DAT_HI=7, DAT_LO=0);
  - markers CFG_END=16'hFFFF and CFG_DELAY=16'hFFFE;
  - the state enum;
  - the OV5640 SCCB device address 8'h78, for the master.
- Sub-module: cfg_ms_timer (load/count/zero flag, 32-bit), instantiated once. The ROM contents and the SCCB master are separate existing blocks.

Test Plan:
- MS_CYCLES=10, all T_*=1 except T_BOOT_MS=2; start pulse -> cam_pwdn falls at +10 cycles, cam_resetb rises at +20, first sccb_req at +40+FETCH/DECODE (+42).
- ROM {0x3008,0x82},{0x3103,0x03},{FFFF,xx}; master acks after 5 cycles -> two writes with exact addr/data, then cfg_done=1, busy=0, no third req.
- ROM {0x3008,0x82},{FFFE,0x03},{0x3103,0x03},{FFFF}; MS_CYCLES=10 -> ≥30 cycles between the first sccb_done and the second sccb_req. {FFFE,0x00} -> no added wait.
- NACK the entry at index 1 three times, then ack -> 4 reqs with identical addr/data, 1-cycle low gaps, then normal completion. NACK four times -> cfg_error=1, err_index=1, sccb_req=0.
- Assert reset while sccb_req=1 in WAIT_ACK -> all outputs take reset values asynchronously. Pulse start during busy -> ignored. Pulse start in DONE -> full power sequence repeats from index 0.
- ROM_AW=2 with no end marker -> exactly 4 writes, then DONE with rom_addr=3 (no wrap to 0).
